scatter_hls_deadlock_report_ctrl: RTL and testbench



---
 rtl/scatter_hls_dl_pkg.sv | 21 ++
 rtl/scatter_hls_dl_prio_enc.sv | 23 ++
 rtl/scatter_hls_deadlock_report_ctrl.sv | 125 ++++++++++++
 tb/tb_scatter_hls_deadlock_report_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scatter_hls_dl_pkg.sv
// Shared types for the scatter HLS deadlock report controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package scatter_hls_dl_pkg;

  // Controller phases: wait for a detect, pulse the origin, follow the token,
  // present the report, then hold the deadlock until software rearms.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_TRACE  = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } dl_state_t;

  // Index width for n processes; a single process still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scatter_hls_dl_prio_enc.sv
// Lowest-set-bit priority encoder over the per-process detect flags.
// Latency: combinational.
// Backpressure: none.
// Ports: req (flag vector), idx (lowest set index), any (some bit set).
module scatter_hls_dl_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Scan downward so the last match, the lowest index, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/scatter_hls_deadlock_report_ctrl.sv
// Elects a deadlock origin, launches and tracks the report token, reports the cycle.
// Latency: origin pulse 1 cycle after first detect; report 1 cycle after token return/timeout.
// Backpressure: report held stable while report_ready is low; units stay frozen until rearm.
// Ports: dl_detect_vec in from units; dl_detect_in/origin_vec/token_clear out to units;
//        report_* valid/ready payload to the consumer; rearm restarts after DONE.
module scatter_hls_deadlock_report_ctrl
  import scatter_hls_dl_pkg::*;
#(
  parameter int PROC_NUM = 4,
  parameter int TIMEOUT  = 1024,
  parameter int TIMER_W  = 16,
  localparam int IW      = idx_w(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic                report_ready,
  input  logic                rearm,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                report_valid,
  output logic [PROC_NUM-1:0] report_proc_mask,
  output logic [IW-1:0]       report_origin_idx,
  output logic                report_timeout,
  output logic [TIMER_W-1:0]  report_cycles
);

  dl_state_t           state;
  logic [IW-1:0]       origin_idx;
  logic [PROC_NUM-1:0] mask;
  logic [TIMER_W-1:0]  timer;

  logic [IW-1:0]       enc_idx;
  logic                enc_any;
  logic                token_ret;
  logic                timer_last;
  logic [PROC_NUM-1:0] mask_merged;

  scatter_hls_dl_prio_enc #(
    .N  (PROC_NUM),
    .IW (IW)
  ) u_prio_enc (
    .req (dl_detect_vec),
    .idx (enc_idx),
    .any (enc_any)
  );

  // The token is back once the origin unit flags again while tracing.
  assign token_ret   = (state == ST_TRACE) && dl_detect_vec[origin_idx];
  assign timer_last  = (timer == TIMER_W'(TIMEOUT - 1));
  assign mask_merged = mask | dl_detect_vec;

  // Must kill the token in the very cycle it arrives, so not registered.
  assign token_clear = token_ret;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      origin_idx        <= '0;
      mask              <= '0;
      timer             <= '0;
      dl_detect_in      <= 1'b0;
      origin_vec        <= '0;
      report_valid      <= 1'b0;
      report_proc_mask  <= '0;
      report_origin_idx <= '0;
      report_timeout    <= 1'b0;
      report_cycles     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enc_any) begin
            origin_idx   <= enc_idx;
            origin_vec   <= PROC_NUM'(1) << enc_idx;
            dl_detect_in <= 1'b1;
            state        <= ST_ARM;
          end
        end
        ST_ARM: begin
          // Flags seen during the launch cycle are deliberately not merged.
          origin_vec <= '0;
          mask       <= PROC_NUM'(1) << origin_idx;
          timer      <= '0;
          state      <= ST_TRACE;
        end
        ST_TRACE: begin
          mask <= mask_merged;
          if (token_ret || timer_last) begin
            // Token return takes priority over a coincident timeout.
            report_valid      <= 1'b1;
            report_proc_mask  <= mask_merged;
            report_origin_idx <= origin_idx;
            report_timeout    <= !token_ret;
            report_cycles     <= timer;
            state             <= ST_REPORT;
          end else begin
            // Exit at TIMEOUT-1 keeps the timer from ever wrapping.
            timer <= timer + TIMER_W'(1);
          end
        end
        ST_REPORT: begin
          if (report_ready) begin
            report_valid <= 1'b0;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rearm) begin
            dl_detect_in      <= 1'b0;
            mask              <= '0;
            timer             <= '0;
            report_proc_mask  <= '0;
            report_origin_idx <= '0;
            report_timeout    <= 1'b0;
            report_cycles     <= '0;
            state             <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scatter_hls_deadlock_report_ctrl.sv
module tb_scatter_hls_deadlock_report_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  dl_detect_vec = 4'b0;
  logic        report_ready = 1'b0;
  logic        rearm = 1'b0;
  logic        dl_detect_in;
  logic [3:0]  origin_vec;
  logic        token_clear;
  logic        report_valid;
  logic [3:0]  report_proc_mask;
  logic [1:0]  report_origin_idx;
  logic        report_timeout;
  logic [15:0] report_cycles;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  mask;
    logic [1:0]  idx;
    logic        to;
    logic [15:0] cyc;
  } rpt_t;

  rpt_t exp_q[$];

  scatter_hls_deadlock_report_ctrl #(
    .PROC_NUM (4),
    .TIMEOUT  (8),
    .TIMER_W  (16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .dl_detect_vec     (dl_detect_vec),
    .report_ready      (report_ready),
    .rearm             (rearm),
    .dl_detect_in      (dl_detect_in),
    .origin_vec        (origin_vec),
    .token_clear       (token_clear),
    .report_valid      (report_valid),
    .report_proc_mask  (report_proc_mask),
    .report_origin_idx (report_origin_idx),
    .report_timeout    (report_timeout),
    .report_cycles     (report_cycles)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_dl"},   dl_detect_in, 0);
    check_val({tag, "_ov"},   origin_vec, 0);
    check_val({tag, "_tc"},   token_clear, 0);
    check_val({tag, "_vld"},  report_valid, 0);
    check_val({tag, "_mask"}, report_proc_mask, 0);
    check_val({tag, "_idx"},  report_origin_idx, 0);
    check_val({tag, "_to"},   report_timeout, 0);
    check_val({tag, "_cyc"},  report_cycles, 0);
  endtask

  // Scoreboard: pop one expected report per accepted handshake.
  always @(negedge clock) begin
    rpt_t e;
    if (reset && report_valid && report_ready) begin
      if (exp_q.size() == 0) begin
        check_val("rpt_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_val("rpt_mask", report_proc_mask, e.mask);
        check_val("rpt_idx",  report_origin_idx, e.idx);
        check_val("rpt_to",   report_timeout, e.to);
        check_val("rpt_cyc",  report_cycles, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic tc_seen;

    #12;
    check_all_zero("reset");
    reset = 1'b1;

    // Token return: origin 2, flags 0010, 1000, then origin returns.
    dl_detect_vec = 4'b0100;
    step();
    check_val("arm_ov", origin_vec, 4'b0100);
    check_val("arm_dl", dl_detect_in, 1);
    check_val("arm_tc", token_clear, 0);
    dl_detect_vec = 4'b0001;  // must not enter the mask
    step();
    check_val("trace_ov", origin_vec, 0);
    check_val("trace_dl", dl_detect_in, 1);
    dl_detect_vec = 4'b0010;
    #1 check_val("tc_c0", token_clear, 0);
    step();
    dl_detect_vec = 4'b1000;
    #1 check_val("tc_c1", token_clear, 0);
    step();
    dl_detect_vec = 4'b0100;
    #1 check_val("tc_ret", token_clear, 1);
    exp_q.push_back('{mask: 4'b1110, idx: 2'd2, to: 1'b0, cyc: 16'd2});
    step();
    dl_detect_vec = 4'b0000;
    check_val("rep_vld", report_valid, 1);
    // Stall five cycles; a rearm pulse here must be ignored.
    for (int i = 0; i < 5; i++) begin
      rearm = (i == 2);
      step();
      check_val("hold_vld",  report_valid, 1);
      check_val("hold_mask", report_proc_mask, 4'b1110);
      check_val("hold_idx",  report_origin_idx, 2);
      check_val("hold_cyc",  report_cycles, 2);
    end
    rearm = 1'b0;
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    check_val("done_vld", report_valid, 0);
    check_val("done_dl",  dl_detect_in, 1);
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    check_val("rearm_dl", dl_detect_in, 0);

    // Lowest index wins; then timeout with no return.
    dl_detect_vec = 4'b1010;
    step();
    check_val("prio_ov", origin_vec, 4'b0010);
    dl_detect_vec = 4'b1000;
    report_ready = 1'b1;  // ignored until REPORT
    exp_q.push_back('{mask: 4'b1010, idx: 2'd1, to: 1'b1, cyc: 16'd7});
    n = 0;
    tc_seen = 1'b0;
    do begin
      step();
      n++;
      tc_seen = tc_seen | token_clear;
    end while (!report_valid && n < 30);
    check_val("to_cycles_to_report", n, 9);
    check_val("to_tc_never", tc_seen, 0);
    step();
    check_val("to_vld_drop", report_valid, 0);
    dl_detect_vec = 4'b0000;
    report_ready = 1'b0;
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    check_val("to_rearm_dl", dl_detect_in, 0);

    // Asynchronous reset during TRACE, then a fresh run.
    dl_detect_vec = 4'b0100;
    step();
    dl_detect_vec = 4'b0000;
    step();
    step();
    #1 reset = 1'b0;
    #1 check_all_zero("midrst");
    #3 reset = 1'b1;
    dl_detect_vec = 4'b0001;
    step();
    check_val("re_ov", origin_vec, 4'b0001);
    step();
    #1 check_val("re_tc", token_clear, 1);
    exp_q.push_back('{mask: 4'b0001, idx: 2'd0, to: 1'b0, cyc: 16'd0});
    report_ready = 1'b1;
    step();
    dl_detect_vec = 4'b0000;
    step();
    check_val("re_vld_drop", report_valid, 0);
    report_ready = 1'b0;

    check_val("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
